// File: rtl/disp_scan_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit
// multiplexed seven-segment scan with active-low anodes and leading-zero blanking.
module disp_scan_driver #(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    input  logic             blank_lz,
    output logic             busy,
    output logic [3:0]       bcd,
    output logic [3:0]       an
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic             r_busy;
    logic [BIN_W-1:0] r_sr;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_ovf_disp;
    logic [3:0][3:0]  r_d;
    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_idx;

    logic [15:0]      w_acc_adj;
    logic             w_ovf;
    logic [3:0]       w_zero_from;
    logic             w_blank;

    function automatic logic [15:0] add3_all(input logic [15:0] acc);
        logic [15:0] res;
        res = acc;
        for (int k = 0; k < 4; k++) begin
            if (acc[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end else begin
                res[4*k +: 4] = acc[4*k +: 4];
            end
        end
        return res;
    endfunction

    assign w_acc_adj = add3_all(r_acc);
    assign w_ovf     = (32'(bin_in) > 32'd9999);

    // Conversion FSM; digits are only replaced in DONE so the display never shows partial results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_sr       <= '0;
            r_acc      <= 16'd0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_ovf_disp <= 1'b0;
            r_d        <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bin_valid) begin
                        r_sr    <= bin_in;
                        r_acc   <= 16'd0;
                        r_cnt   <= '0;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {r_acc, r_sr} <= {w_acc_adj[14:0], r_sr, 1'b0};
                    r_cnt         <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_d        <= r_ovf ? 16'hEEEE : r_acc;
                    r_ovf_disp <= r_ovf;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running digit scan, independent of conversion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (r_pre == PRE_W'(REFRESH_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // w_zero_from[k]: digits k..3 are all zero
    always_comb begin
        w_zero_from    = 4'd0;
        w_zero_from[3] = (r_d[3] == 4'd0);
        for (int k = 2; k >= 0; k--) begin
            w_zero_from[k] = w_zero_from[k+1] && (r_d[k] == 4'd0);
        end
    end

    assign w_blank = blank_lz && (r_idx != 2'd0) && !r_ovf_disp && w_zero_from[r_idx];
    assign bcd     = r_d[r_idx];
    assign an      = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
    assign busy    = r_busy;

endmodule

// File: tb/tb_disp_scan_driver.sv
// Scoreboard bench for disp_scan_driver: expected digits are queued at load
// time and popped when busy falls; a bench-side scan model predicts an/bcd.
module tb_disp_scan_driver;

    localparam int BIN_W       = 14;
    localparam int REFRESH_DIV = 4;

    typedef struct {
        logic [15:0] d;
        logic        ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [BIN_W-1:0] bin_in;
    logic             bin_valid;
    logic             blank_lz;
    logic             busy;
    logic [3:0]       bcd;
    logic [3:0]       an;

    int    n_chk  = 0;
    int    n_pass = 0;
    exp_t  sb[$];
    logic [15:0] m_d   = 16'd0;
    logic        m_ovf = 1'b0;
    int    m_pre = 0;
    int    m_idx = 0;

    disp_scan_driver #(.BIN_W(BIN_W), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_in   (bin_in),
        .bin_valid(bin_valid),
        .blank_lz (blank_lz),
        .busy     (busy),
        .bcd      (bcd),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Reference scan position
    always @(posedge clk) begin
        if (rst) begin
            m_pre <= 0;
            m_idx <= 0;
        end else if (m_pre == REFRESH_DIV - 1) begin
            m_pre <= 0;
            m_idx <= (m_idx + 1) % 4;
        end else begin
            m_pre <= m_pre + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t exp_from(input int v);
        exp_t e;
        if (v > 9999) begin
            e.d   = 16'hEEEE;
            e.ovf = 1'b1;
        end else begin
            e.d   = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [3:0] exp_an();
        logic blank;
        blank = blank_lz && (m_idx != 0) && !m_ovf && ((m_d >> (4 * m_idx)) == 16'd0);
        return blank ? 4'b1111 : ~(4'b0001 << m_idx);
    endfunction

    task automatic check_display(input string tag);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_an"}, 32'(an), 32'(exp_an()));
            check({tag, "_bcd"}, 32'(bcd), 32'(m_d[4*m_idx +: 4]));
            repeat (REFRESH_DIV) tick();
        end
    endtask

    // Load val; optionally fire a second strobe at busy cycle intr_cycle (must be dropped)
    task automatic convert(input int val, input int intr_cycle, input int intr_val, input string tag);
        int   cnt;
        exp_t e;
        bin_in    = 14'(val);
        bin_valid = 1'b1;
        sb.push_back(exp_from(val));
        tick();
        bin_valid = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            check({tag, "_hold_bcd"}, 32'(bcd), 32'(m_d[4*m_idx +: 4]));
            if (cnt == intr_cycle) begin
                bin_in    = 14'(intr_val);
                bin_valid = 1'b1;
            end
            tick();
            bin_valid = 1'b0;
        end
        check({tag, "_busy_len"}, 32'(cnt), 32'd15);
        e     = sb.pop_front();
        m_d   = e.d;
        m_ovf = e.ovf;
        check({tag, "_first_bcd"}, 32'(bcd), 32'(m_d[4*m_idx +: 4]));
        tick();
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check_display(tag);
    endtask

    initial begin
        logic [3:0] seq [4];
        seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst = 1'b1; bin_in = '0; bin_valid = 1'b0; blank_lz = 1'b0;
        tick();
        tick();
        check("rst_an", 32'(an), 32'(4'b1110));
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("scan_an", 32'(an), 32'(seq[k % 4]));
            repeat (REFRESH_DIV) tick();
        end

        convert(1234, -1, 0, "v1234");
        convert(9999, -1, 0, "v9999");
        convert(0, -1, 0, "v0");
        blank_lz = 1'b1;
        convert(10000, -1, 0, "ovf");
        convert(7, -1, 0, "lz7");
        convert(305, -1, 0, "lz305");
        convert(0, -1, 0, "lz0");
        blank_lz = 1'b0;

        convert(1234, -1, 0, "pre_drop");
        convert(5678, 5, 42, "drop42");
        convert(2468, 15, 42, "drop_done");

        // Reset in the middle of a conversion
        bin_in    = 14'd4321;
        bin_valid = 1'b1;
        sb.push_back(exp_from(4321));
        tick();
        bin_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        void'(sb.pop_front());
        m_d   = 16'd0;
        m_ovf = 1'b0;
        check_display("abort");
        convert(4321, -1, 0, "v4321");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
